// File: rtl/adder_response_checker_pkg.sv
// adder_response_checker_pkg: shared state encoding and sizing constants for the adder response checker
package adder_response_checker_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int ERR_W = 16;
  localparam int WIDTH_DEF = 4;
endpackage

// File: rtl/adder_golden_model.sv
// adder_golden_model: combinational reference sum {carry, sum} = x + y + cin
module adder_golden_model #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_cin,
  output logic [WIDTH:0]   o_sum
);
  assign o_sum = (WIDTH+1)'(i_x) + (WIDTH+1)'(i_y) + (WIDTH+1)'(i_cin);
endmodule

// File: rtl/adder_response_checker.sv
// adder_response_checker: checks observed adder responses against a golden sum, tracking errors, coverage and first failure
module adder_response_checker
  import adder_response_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_valid,
  input  logic [WIDTH-1:0]     i_x,
  input  logic [WIDTH-1:0]     i_y,
  input  logic                 i_cprev,
  input  logic [WIDTH-1:0]     i_res,
  input  logic                 i_cnext,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [ERR_W-1:0]     o_err_cnt,
  output logic [2*WIDTH+1:0]   o_cov_cnt,
  output logic                 o_fail_valid,
  output logic [2*WIDTH:0]     o_fail_vec
);
  localparam int VW = 2*WIDTH+1;
  localparam int NCODE = 1 << VW;
  localparam int CW = 2*WIDTH+2;
  state_t           r_state;
  logic [NCODE-1:0] r_bitmap;
  logic [ERR_W-1:0] r_err_cnt;
  logic [CW-1:0]    r_cov_cnt;
  logic             r_fail_valid;
  logic [VW-1:0]    r_fail_vec;
  logic [VW-1:0]    w_code;
  logic [WIDTH:0]   w_exp;
  logic             w_accept;
  logic             w_mismatch;
  logic             w_new;
  logic             w_last;
  adder_golden_model #(.WIDTH(WIDTH)) u_gold (
    .i_x   (i_x),
    .i_y   (i_y),
    .i_cin (i_cprev),
    .o_sum (w_exp)
  );
  assign w_code     = {i_cprev, i_x, i_y};
  assign w_accept   = (r_state == RUN) && i_valid && !i_start;
  assign w_mismatch = {i_cnext, i_res} != w_exp;
  assign w_new      = !r_bitmap[w_code];
  // the sample that fills the last bitmap hole also ends the run
  assign w_last     = w_new && (r_cov_cnt == CW'(NCODE-1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_bitmap     <= '0;
      r_err_cnt    <= '0;
      r_cov_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (i_start) begin
      r_state      <= RUN;
      r_bitmap     <= '0;
      r_err_cnt    <= '0;
      r_cov_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (w_accept) begin
      r_bitmap[w_code] <= 1'b1;
      if (w_new) r_cov_cnt <= r_cov_cnt + 1'b1;
      if (w_last) r_state <= DONE;
      if (w_mismatch && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      if (w_mismatch && !r_fail_valid) begin
        r_fail_valid <= 1'b1;
        r_fail_vec   <= w_code;
      end
    end
  end
  assign o_busy       = r_state == RUN;
  assign o_done       = r_state == DONE;
  assign o_pass       = (r_state == DONE) && (r_err_cnt == '0);
  assign o_err_cnt    = r_err_cnt;
  assign o_cov_cnt    = r_cov_cnt;
  assign o_fail_valid = r_fail_valid;
  assign o_fail_vec   = r_fail_vec;
endmodule

// File: doc/adder_response_checker.md
ADDER_RESPONSE_CHECKER -- requirements
Module: adder_response_checker

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 1..4.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 START  input  1  one-cycle pulse that clears results and arms checking.
REQ-005 VALID  input  1  high when X, Y, Cprev, RES and Cnext form one sample.
REQ-006 X  input  WIDTH  adder operand X as applied to the adder under test.
REQ-007 Y  input  WIDTH  adder operand Y as applied to the adder under test.
REQ-008 Cprev  input  1  carry-in as applied to the adder under test.
REQ-009 RES  input  WIDTH  sum output observed from the adder under test.
REQ-010 Cnext  input  1  carry-out observed from the adder under test.
REQ-011 BUSY  output  1  high while in state RUN.
REQ-012 DONE  output  1  high while in state DONE.
REQ-013 PASS  output  1  DONE and ERR_CNT equal to zero.
REQ-014 ERR_CNT  output  16  count of mismatching samples; saturates at 0xFFFF.
REQ-015 COV_CNT  output  2*WIDTH+2  number of distinct {Cprev,X,Y} codes checked.
REQ-016 FAIL_VALID  output  1  high once a first mismatch has been captured.
REQ-017 FAIL_VEC  output  2*WIDTH+1  {Cprev,X,Y} of the first mismatching sample.

Function
REQ-018 FSM states: IDLE, RUN, DONE; transitions occur only on the rising edge of CLK.
REQ-019 IDLE -> RUN on START; RUN -> RUN on START (restart); DONE -> RUN on START.
REQ-020 On a START edge, ERR_CNT, COV_CNT, FAIL_VALID, FAIL_VEC and the coverage bitmap clear to zero.
REQ-021 Expected result: {exp_c, exp_s} = X + Y + Cprev, computed to WIDTH+1 bits.
REQ-022 A sample is accepted only in RUN, with VALID high and START low; VALID in IDLE or DONE is ignored.
REQ-023 If START and VALID are high in the same cycle, START wins and the sample is dropped.
REQ-024 Mismatch means {Cnext,RES} differs from {exp_c,exp_s}; ERR_CNT increments one cycle after acceptance (latency 1).
REQ-025 On the first mismatch after START, FAIL_VEC captures {Cprev,X,Y} and FAIL_VALID sets; later mismatches do not overwrite them.
REQ-026 A 2^(2*WIDTH+1)-bit bitmap, indexed by {Cprev,X,Y}, sets its bit on each accepted sample; COV_CNT increments only when that bit was previously clear.
REQ-027 Duplicate codes are still checked and counted toward ERR_CNT.
REQ-028 When the accepted sample sets the final bitmap bit, the FSM enters DONE on the same edge that updates COV_CNT to 2^(2*WIDTH+1).
REQ-029 ERR_CNT holds at 0xFFFF and does not wrap.
REQ-030 PASS, DONE and BUSY are decoded from registered state only, with no combinational path from inputs.

Reset
REQ-031 RST_N low forces IDLE and zeroes the bitmap, ERR_CNT, COV_CNT, FAIL_VALID and FAIL_VEC; BUSY, DONE and PASS are therefore 0.
REQ-032 Reset asserted mid-RUN discards all progress; checking resumes only after a new START.
REQ-033 After RST_N deasserts, the block remains in IDLE until START.

Structure
REQ-034 A shared package holds the FSM state enum (IDLE, RUN, DONE), the ERR_CNT width constant (16) and the WIDTH default (4).
REQ-035 A sub-module adder_golden_model (combinational, WIDTH-parameterised) produces {exp_c, exp_s}.
REQ-036 The FSM, the counters, the bitmap and the first-fail capture are in adder_response_checker.

Verification
REQ-037 WIDTH=1: START, then all 8 codes with correct outputs -> DONE=1, PASS=1, COV_CNT=8, ERR_CNT=0, FAIL_VALID=0.
REQ-038 WIDTH=1: code {Cprev,X,Y}=3'b011 with RES=1, Cnext=0 -> ERR_CNT=1, FAIL_VEC=3'b011, FAIL_VALID=1; PASS=0 at DONE.
REQ-039 WIDTH=4: code 9'h1FF sent three times before the remaining codes -> COV_CNT counts it once; DONE follows only after all 512 codes.
REQ-040 START and VALID high in the same cycle during RUN -> counters clear, sample dropped, COV_CNT=0 on the next cycle.
REQ-041 RST_N pulsed low after 5 samples -> state IDLE and all outputs zero immediately (asynchronously); VALID ignored until START.
REQ-042 70000 forced mismatches -> ERR_CNT saturates at 0xFFFF.
